// File: rtl/vc_stream_demux.sv
// One-to-N val/rdy stream demultiplexer with a 2-entry FIFO per output port.
// Define VC_STREAM_DEMUX_BYPASS_EN to let a message pass straight through to an empty port.
module vc_stream_demux #(
    parameter int p_nbits   = 32,
    parameter int p_nports  = 4,
    parameter int p_selbits = $clog2(p_nports)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_nbits-1:0]          in_msg,
    input  logic [p_selbits-1:0]        in_sel,
    output logic [p_nports-1:0]         out_val,
    input  logic [p_nports-1:0]         out_rdy,
    output logic [p_nports*p_nbits-1:0] out_msg,
    output logic [7:0]                  drop_count
);

    localparam logic [p_selbits:0] sel_lim = (p_selbits+1)'(p_nports);

    logic [p_nbits-1:0]  mem [p_nports][2];
    logic [1:0]          cnt [p_nports];
    logic [p_nports-1:0] head;
    logic [p_nports-1:0] tail;
    logic                sel_legal;
    logic [p_nports-1:0] hit;
    logic [p_nports-1:0] wr;
    logic [p_nports-1:0] rd;

    // Out-of-range selects are always accepted and discarded.
    assign sel_legal = ({1'b0, in_sel} < sel_lim);

    always_comb begin
        in_rdy = 1'b1;
        hit    = '0;
        for (int i = 0; i < p_nports; i++) begin
            if (sel_legal && in_sel == p_selbits'(i)) begin
                hit[i] = in_val;
                in_rdy = (cnt[i] != 2'd2);
            end
        end
    end

    always_comb begin
        out_val = '0;
        out_msg = '0;
        wr      = '0;
        rd      = '0;
        for (int i = 0; i < p_nports; i++) begin
            out_val[i]                    = (cnt[i] != 2'd0);
            out_msg[i*p_nbits +: p_nbits] = mem[i][head[i]];
            rd[i]                         = out_val[i] && out_rdy[i];
            wr[i]                         = hit[i] && in_rdy;
`ifdef VC_STREAM_DEMUX_BYPASS_EN
            // Empty port: present the input directly; only store it if the consumer stalls.
            if (cnt[i] == 2'd0 && hit[i]) begin
                out_val[i]                    = 1'b1;
                out_msg[i*p_nbits +: p_nbits] = in_msg;
                wr[i]                         = !out_rdy[i];
                rd[i]                         = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_nports; i++) cnt[i] <= 2'd0;
            head       <= '0;
            tail       <= '0;
            drop_count <= 8'd0;
        end else begin
            for (int i = 0; i < p_nports; i++) begin
                if (wr[i]) tail[i] <= ~tail[i];
                if (rd[i]) head[i] <= ~head[i];
                cnt[i] <= cnt[i] + {1'b0, wr[i]} - {1'b0, rd[i]};
            end
            if (in_val && !sel_legal && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
        end
    end

    // Payload storage carries no reset; validity lives entirely in cnt.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_nports; i++) begin
            if (wr[i]) mem[i][tail[i]] <= in_msg;
        end
    end

endmodule

// File: tb/tb_vc_stream_demux.sv
// Directed and randomized checks for vc_stream_demux (5 ports, 32-bit messages).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_vc_stream_demux;

    localparam int NB = 32;
    localparam int NP = 5;
    localparam int SB = 3;

    logic             clk;
    logic             reset;
    logic             in_val;
    logic             in_rdy;
    logic [NB-1:0]    in_msg;
    logic [SB-1:0]    in_sel;
    logic [NP-1:0]    out_val;
    logic [NP-1:0]    out_rdy;
    logic [NP*NB-1:0] out_msg;
    logic [7:0]       drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [NB-1:0] exp_q [NP][$];

    vc_stream_demux #(.p_nbits(NB), .p_nports(NP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_msg     (in_msg),
        .in_sel     (in_sel),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .drop_count (drop_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic next_cycle(input logic v, input logic [SB-1:0] s, input logic [NB-1:0] m);
        @(posedge clk);
        #1;
        in_val = v;
        in_sel = s;
        in_msg = m;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        in_val  = 1'b0;
        out_rdy = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_val !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_out_val: got %b exp 00000", out_val);
        end
        n_cmp++;
        if (drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_drop: got %0d exp 0", drop_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_in_rdy: got %b exp 1", in_rdy);
        end
        n_cmp++;
        if (out_val !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_out_val: got %b exp 00000", out_val);
        end
        // two messages parked on port 1, then an asynchronous reset mid-cycle
        next_cycle(1'b1, 3'd1, 32'h11);
        next_cycle(1'b1, 3'd1, 32'h12);
        next_cycle(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (out_val[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_flush_val: got %b exp 1", out_val[1]);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_val[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_flush_val: got %b exp 0", out_val[1]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_val !== 5'b0 || in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush: got val=%b rdy=%b exp val=00000 rdy=1", out_val, in_rdy);
        end
    endtask

    task automatic test_fill_drain();
        out_rdy = '0;
        next_cycle(1'b1, 3'd2, 32'hA);
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_rdy_a: got %b exp 1", in_rdy);
        end
        next_cycle(1'b1, 3'd2, 32'hB);
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1 || out_val[2] !== 1'b1 || out_msg[2*NB +: NB] !== 32'hA) begin
            n_fail++;
            $display("FAIL fill_b: got rdy=%b val=%b msg=%h exp rdy=1 val=1 msg=a",
                     in_rdy, out_val[2], out_msg[2*NB +: NB]);
        end
        next_cycle(1'b1, 3'd2, 32'hC);
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rdy: got %b exp 0", in_rdy);
        end
        @(posedge clk);
        #1;
        out_rdy[2] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b0 || out_msg[2*NB +: NB] !== 32'hA) begin
            n_fail++;
            $display("FAIL full_deq_rdy: got rdy=%b msg=%h exp rdy=0 msg=a", in_rdy, out_msg[2*NB +: NB]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1 || out_val[2] !== 1'b1 || out_msg[2*NB +: NB] !== 32'hB) begin
            n_fail++;
            $display("FAIL drain_b: got rdy=%b val=%b msg=%h exp rdy=1 val=1 msg=b",
                     in_rdy, out_val[2], out_msg[2*NB +: NB]);
        end
        next_cycle(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (out_val[2] !== 1'b1 || out_msg[2*NB +: NB] !== 32'hC) begin
            n_fail++;
            $display("FAIL drain_c: got val=%b msg=%h exp val=1 msg=c", out_val[2], out_msg[2*NB +: NB]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (out_val[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got %b exp 0", out_val[2]);
        end
        out_rdy = '0;
    endtask

    task automatic test_isolation();
        out_rdy = '0;
        next_cycle(1'b1, 3'd0, 32'h01);
        next_cycle(1'b1, 3'd0, 32'h02);
        next_cycle(1'b1, 3'd3, 32'h55);
        out_rdy[3] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_rdy: got %b exp 1", in_rdy);
        end
`ifdef VC_STREAM_DEMUX_BYPASS_EN
        n_cmp++;
        if (out_val[3] !== 1'b1 || out_msg[3*NB +: NB] !== 32'h55) begin
            n_fail++;
            $display("FAIL iso_bypass: got val=%b msg=%h exp val=1 msg=55", out_val[3], out_msg[3*NB +: NB]);
        end
`endif
        next_cycle(1'b1, 3'd0, 32'h99);
        @(negedge clk);
`ifdef VC_STREAM_DEMUX_BYPASS_EN
        n_cmp++;
        if (out_val[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_p3_after: got %b exp 0", out_val[3]);
        end
`else
        n_cmp++;
        if (out_val[3] !== 1'b1 || out_msg[3*NB +: NB] !== 32'h55) begin
            n_fail++;
            $display("FAIL iso_p3: got val=%b msg=%h exp val=1 msg=55", out_val[3], out_msg[3*NB +: NB]);
        end
`endif
        n_cmp++;
        if (in_rdy !== 1'b0 || out_val[0] !== 1'b1 || out_msg[0 +: NB] !== 32'h01) begin
            n_fail++;
            $display("FAIL iso_p0_held: got rdy=%b val=%b msg=%h exp rdy=0 val=1 msg=01",
                     in_rdy, out_val[0], out_msg[0 +: NB]);
        end
        next_cycle(1'b0, 3'd0, 32'h0);
        out_rdy = 5'b00001;
        @(negedge clk);
        n_cmp++;
        if (out_msg[0 +: NB] !== 32'h01) begin
            n_fail++;
            $display("FAIL iso_p0_first: got %h exp 01", out_msg[0 +: NB]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (out_val[0] !== 1'b1 || out_msg[0 +: NB] !== 32'h02) begin
            n_fail++;
            $display("FAIL iso_p0_second: got val=%b msg=%h exp val=1 msg=02", out_val[0], out_msg[0 +: NB]);
        end
        @(posedge clk);
        #1;
        out_rdy = '0;
        @(negedge clk);
        n_cmp++;
        if (out_val !== 5'b0) begin
            n_fail++;
            $display("FAIL iso_all_empty: got %b exp 00000", out_val);
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 300; i++) begin
            next_cycle(1'b1, 3'd7, NB'(i));
            @(negedge clk);
            n_cmp++;
            if (in_rdy !== 1'b1 || out_val !== 5'b0 || drop_count !== 8'((i > 255) ? 255 : i)) begin
                n_fail++;
                $display("FAIL drop_%0d: got rdy=%b val=%b cnt=%0d exp rdy=1 val=00000 cnt=%0d",
                         i, in_rdy, out_val, drop_count, (i > 255) ? 255 : i);
            end
        end
        next_cycle(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (drop_count !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d exp 255", drop_count);
        end
    endtask

    task automatic test_streaming();
        logic          ev;
        logic [NB-1:0] em;
        out_rdy = 5'b00010;
        for (int c = 0; c < 18; c++) begin
            next_cycle(c < 16, 3'd1, NB'(c + 1));
`ifdef VC_STREAM_DEMUX_BYPASS_EN
            ev = (c < 16);
            em = NB'(c + 1);
`else
            ev = (c >= 1 && c <= 16);
            em = NB'(c);
`endif
            @(negedge clk);
            n_cmp++;
            if (out_val[1] !== ev || (ev && out_msg[NB +: NB] !== em) || (c < 16 && in_rdy !== 1'b1)) begin
                n_fail++;
                $display("FAIL stream_c%0d: got val=%b msg=%h rdy=%b exp val=%b msg=%h",
                         c, out_val[1], out_msg[NB +: NB], in_rdy, ev, em);
            end
        end
        out_rdy = '0;
    endtask

    task automatic test_random();
        int drops;
        int s;
        logic exp_rdy;
        logic [NB-1:0] got;
        drops = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            in_val  = ($urandom_range(0, 9) < 6);
            s       = $urandom_range(0, 39);
            in_sel  = (s < 39) ? SB'(s % 5) : SB'(5 + $urandom_range(0, 2));
            in_msg  = $urandom;
            out_rdy = NP'($urandom_range(0, 31));
            @(negedge clk);
            s = int'(in_sel);
            exp_rdy = (s < NP) ? (exp_q[s].size() < 2) : 1'b1;
            n_cmp++;
            if (in_rdy !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_rdy_c%0d: got %b exp %b", c, in_rdy, exp_rdy);
            end
`ifndef VC_STREAM_DEMUX_BYPASS_EN
            for (int i = 0; i < NP; i++) begin
                n_cmp++;
                if (out_val[i] !== (exp_q[i].size() != 0)) begin
                    n_fail++;
                    $display("FAIL rand_val_c%0d_p%0d: got %b exp %b", c, i, out_val[i], exp_q[i].size() != 0);
                end
            end
`endif
            if (in_val && in_rdy) begin
                if (s < NP) exp_q[s].push_back(in_msg);
                else        drops++;
            end
            for (int i = 0; i < NP; i++) begin
                if (out_val[i] && out_rdy[i]) begin
                    got = out_msg[i*NB +: NB];
                    n_cmp++;
                    if (exp_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_dup_c%0d_p%0d: got %h exp no message", c, i, got);
                    end else if (got !== exp_q[i][0]) begin
                        n_fail++;
                        $display("FAIL rand_order_c%0d_p%0d: got %h exp %h", c, i, got, exp_q[i][0]);
                        void'(exp_q[i].pop_front());
                    end else begin
                        void'(exp_q[i].pop_front());
                    end
                end
            end
        end
        // drain: every port empties within two ready cycles
        @(posedge clk);
        #1;
        in_val  = 1'b0;
        out_rdy = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (out_val[i]) begin
                    got = out_msg[i*NB +: NB];
                    n_cmp++;
                    if (exp_q[i].size() == 0 || got !== exp_q[i][0]) begin
                        n_fail++;
                        $display("FAIL drain_p%0d: got %h exp %h", i, got,
                                 (exp_q[i].size() == 0) ? 32'h0 : exp_q[i][0]);
                    end
                    if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NP; i++) begin
            n_cmp++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("FAIL rand_loss_p%0d: got %0d undelivered exp 0", i, exp_q[i].size());
            end
        end
        n_cmp++;
        if (drop_count !== 8'((drops > 255) ? 255 : drops)) begin
            n_fail++;
            $display("FAIL rand_drops: got %0d exp %0d", drop_count, (drops > 255) ? 255 : drops);
        end
        out_rdy = '0;
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_sel  = '0;
        in_msg  = '0;
        out_rdy = '0;
        test_reset();
        test_fill_drain();
        test_isolation();
        test_drop();
        test_streaming();
        test_random();
        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
